// File: rtl/lap_disp_pkg.sv
// Shared types for the lap capture / display selection block.
// FSM state encoding and the display-source constant for running time.
package lap_disp_pkg;

  typedef enum logic {
    SHOW_RUN = 1'b0,
    SHOW_LAP = 1'b1
  } state_e;

  localparam int SRC_RUNNING = 0;

endpackage

// File: rtl/lap_display_ctrl_if.sv
// Request/display bundle between the stopwatch core and the lap block.
// master drives running time and pulses; slave returns display state.
interface lap_display_ctrl_if #(
  parameter int TIME_W = 16,
  parameter int SRC_W  = 3
);

  logic [TIME_W-1:0] running_time;
  logic              lap_pulse;
  logic              next_pulse;
  logic              clear;
  logic [TIME_W-1:0] display;
  logic [SRC_W-1:0]  display_src;
  logic [SRC_W-1:0]  lap_count;
  logic              lap_overflow;

  modport master (
    output running_time,
    output lap_pulse,
    output next_pulse,
    output clear,
    input  display,
    input  display_src,
    input  lap_count,
    input  lap_overflow
  );

  modport slave (
    input  running_time,
    input  lap_pulse,
    input  next_pulse,
    input  clear,
    output display,
    output display_src,
    output lap_count,
    output lap_overflow
  );

endinterface

// File: rtl/lap_store.sv
// Lap time register file: one write port, combinational read.
// Data is not reset; only slots below lap_count are ever read.
module lap_store #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int IW    = 3
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_widx,
  input  logic [W-1:0]  i_wdata,
  input  logic [IW-1:0] i_ridx,
  output logic [W-1:0]  o_rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we && (i_widx < IW'(DEPTH)))
      r_mem[i_widx[AW-1:0]] <= i_wdata;
  end

  always_comb begin
    o_rdata = '0;
    if (i_ridx < IW'(DEPTH))
      o_rdata = r_mem[i_ridx[AW-1:0]];
  end

endmodule

// File: rtl/lap_display_ctrl.sv
// Lap capture, next-step display selection and registered display word.
// Define LAP_DISP_TIMEOUT_EN to add the HOLD_CYCLES auto-return timer.
module lap_display_ctrl
  import lap_disp_pkg::*;
#(
  parameter int TIME_W      = 16,
  parameter int LAP_DEPTH   = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input logic                clk,
  input logic                rst_n,
  lap_display_ctrl_if.slave  bus
);

  localparam int SRC_W = $clog2(LAP_DEPTH + 1);
  localparam logic [SRC_W-1:0] DEPTH_C = SRC_W'(LAP_DEPTH);
  localparam logic [SRC_W-1:0] SRC_RUN_C = SRC_W'(SRC_RUNNING);

  if (LAP_DEPTH < 2 || LAP_DEPTH > 15) begin : g_bad_depth
    $error("lap_display_ctrl: LAP_DEPTH out of range");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("lap_display_ctrl: HOLD_CYCLES must be >= 1");
  end

  state_e            r_state;
  state_e            w_state_nx;
  logic [SRC_W-1:0]  r_src;
  logic [SRC_W-1:0]  w_src_nx;
  logic [SRC_W-1:0]  r_cnt;
  logic [SRC_W-1:0]  w_cnt_nx;
  logic              r_ovf;
  logic              w_ovf_nx;
  logic [TIME_W-1:0] r_disp;
  logic [TIME_W-1:0] w_disp_nx;
  logic [TIME_W-1:0] w_rdata;
  logic [SRC_W-1:0]  w_ridx;
  logic              w_full;
  logic              w_we;

`ifdef LAP_DISP_TIMEOUT_EN
  localparam int TMR_W = $clog2(HOLD_CYCLES + 1);
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nx;
  logic             w_step;
  logic             w_expire;
`endif

  always_comb begin
    w_full     = (r_cnt == DEPTH_C);
    w_we       = bus.lap_pulse & ~bus.clear & ~w_full;
    w_state_nx = r_state;
    w_src_nx   = r_src;
    w_cnt_nx   = r_cnt;
    w_ovf_nx   = r_ovf;
`ifdef LAP_DISP_TIMEOUT_EN
    w_expire = (r_state == SHOW_LAP) && (r_tmr == TMR_W'(1));
`endif
    if (bus.clear) begin
      w_state_nx = SHOW_RUN;
      w_src_nx   = SRC_RUN_C;
      w_cnt_nx   = '0;
      w_ovf_nx   = 1'b0;
    end else begin
      if (bus.lap_pulse) begin
        if (w_full) w_ovf_nx = 1'b1;
        else        w_cnt_nx = r_cnt + 1'b1;
      end
      // next_pulse sees the pre-edge lap count
      if (bus.next_pulse) begin
        unique case (r_state)
          SHOW_RUN: begin
            if (r_cnt != '0) begin
              w_state_nx = SHOW_LAP;
              w_src_nx   = SRC_W'(1);
            end
          end
          SHOW_LAP: begin
            if (r_src < r_cnt) begin
              w_src_nx = r_src + 1'b1;
            end else begin
              w_state_nx = SHOW_RUN;
              w_src_nx   = SRC_RUN_C;
            end
          end
          default: ;
        endcase
      end
`ifdef LAP_DISP_TIMEOUT_EN
      else if (w_expire) begin
        w_state_nx = SHOW_RUN;
        w_src_nx   = SRC_RUN_C;
      end
`endif
    end
    w_ridx    = w_src_nx - 1'b1;
    w_disp_nx = (w_state_nx == SHOW_LAP) ? w_rdata : bus.running_time;
  end

`ifdef LAP_DISP_TIMEOUT_EN
  always_comb begin
    w_step = 1'b0;
    if (bus.next_pulse && !bus.clear)
      w_step = (r_state == SHOW_LAP) ? (r_src < r_cnt)
                                     : (r_cnt != '0);
    w_tmr_nx = r_tmr;
    if (w_step)
      w_tmr_nx = TMR_W'(HOLD_CYCLES);
    else if (w_state_nx == SHOW_RUN)
      w_tmr_nx = '0;
    else if (r_tmr != '0)
      w_tmr_nx = r_tmr - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tmr <= '0;
    else        r_tmr <= w_tmr_nx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SHOW_RUN;
      r_src   <= SRC_RUN_C;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_disp  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_src   <= w_src_nx;
      r_cnt   <= w_cnt_nx;
      r_ovf   <= w_ovf_nx;
      r_disp  <= w_disp_nx;
    end
  end

  lap_store #(
    .DEPTH (LAP_DEPTH),
    .W     (TIME_W),
    .IW    (SRC_W)
  ) u_store (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_widx  (r_cnt),
    .i_wdata (bus.running_time),
    .i_ridx  (w_ridx),
    .o_rdata (w_rdata)
  );

  assign bus.display      = r_disp;
  assign bus.display_src  = r_src;
  assign bus.lap_count    = r_cnt;
  assign bus.lap_overflow = r_ovf;

endmodule

// File: tb/tb_lap_display_ctrl.sv
// Directed vector bench for lap_display_ctrl (LAP_DEPTH=4, HOLD_CYCLES=5).
// Timeout checks follow LAP_DISP_TIMEOUT_EN.
module tb_lap_display_ctrl;

  typedef struct {
    logic [15:0] rt;
    logic        lap;
    logic        nxt;
    logic        clr;
    logic [15:0] disp;
    logic [2:0]  src;
    logic [2:0]  cnt;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vt[$];

  lap_display_ctrl_if #(.TIME_W(16), .SRC_W(3)) bus ();

  lap_display_ctrl #(
    .TIME_W      (16),
    .LAP_DEPTH   (4),
    .HOLD_CYCLES (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic [15:0] rt, logic lap, logic nxt, logic clr,
    logic [15:0] disp, logic [2:0] src, logic [2:0] cnt, logic ovf);
    vec_t v;
    v.rt = rt; v.lap = lap; v.nxt = nxt; v.clr = clr;
    v.disp = disp; v.src = src; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drv(logic [15:0] rt, logic lap, logic nxt, logic clr);
    bus.running_time = rt;
    bus.lap_pulse    = lap;
    bus.next_pulse   = nxt;
    bus.clear        = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string nm, logic [15:0] d, logic [2:0] s,
                         logic [2:0] c, logic o);
    chk({nm, ".disp"}, 32'(bus.display), 32'(d));
    chk({nm, ".src"}, 32'(bus.display_src), 32'(s));
    chk({nm, ".cnt"}, 32'(bus.lap_count), 32'(c));
    chk({nm, ".ovf"}, 32'(bus.lap_overflow), 32'(o));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.running_time = 16'h0;
    bus.lap_pulse    = 1'b0;
    bus.next_pulse   = 1'b0;
    bus.clear        = 1'b0;

    //        rt      lap  nxt  clr  disp    src cnt ovf
    vt.push_back(mk(16'h0123, 0, 0, 0, 16'h0123, 0, 0, 0));
    vt.push_back(mk(16'd10,   1, 0, 0, 16'd10,   0, 1, 0));
    vt.push_back(mk(16'd20,   1, 0, 0, 16'd20,   0, 2, 0));
    vt.push_back(mk(16'd30,   1, 0, 0, 16'd30,   0, 3, 0));
    vt.push_back(mk(16'd40,   0, 1, 0, 16'd10,   1, 3, 0));
    vt.push_back(mk(16'd41,   0, 1, 0, 16'd20,   2, 3, 0));
    vt.push_back(mk(16'd42,   0, 1, 0, 16'd30,   3, 3, 0));
    vt.push_back(mk(16'd43,   0, 1, 0, 16'd43,   0, 3, 0));
    vt.push_back(mk(16'd50,   1, 0, 0, 16'd50,   0, 4, 0));
    vt.push_back(mk(16'd60,   1, 0, 0, 16'd60,   0, 4, 1));
    vt.push_back(mk(16'd61,   0, 1, 0, 16'd10,   1, 4, 1));
    vt.push_back(mk(16'd62,   0, 1, 0, 16'd20,   2, 4, 1));
    vt.push_back(mk(16'd63,   0, 1, 0, 16'd30,   3, 4, 1));
    vt.push_back(mk(16'd64,   0, 1, 0, 16'd50,   4, 4, 1));
    vt.push_back(mk(16'd65,   0, 1, 1, 16'd65,   0, 0, 0));
    vt.push_back(mk(16'd70,   1, 1, 0, 16'd70,   0, 1, 0));
    vt.push_back(mk(16'd71,   0, 1, 0, 16'd70,   1, 1, 0));
    vt.push_back(mk(16'd72,   0, 1, 0, 16'd72,   0, 1, 0));
    vt.push_back(mk(16'd80,   0, 1, 0, 16'd70,   1, 1, 0));
    vt.push_back(mk(16'd90,   0, 0, 0, 16'd70,   1, 1, 0));
    vt.push_back(mk(16'd81,   0, 1, 1, 16'd81,   0, 0, 0));
    vt.push_back(mk(16'd82,   0, 1, 0, 16'd82,   0, 0, 0));
    vt.push_back(mk(16'd83,   1, 0, 1, 16'd83,   0, 0, 0));
    vt.push_back(mk(16'd84,   0, 0, 0, 16'd84,   0, 0, 0));

    #12;
    chk_all("reset", 16'h0, 3'd0, 3'd0, 1'b0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      drv(vt[i].rt, vt[i].lap, vt[i].nxt, vt[i].clr);
      chk_all($sformatf("vec%0d", i), vt[i].disp, vt[i].src,
              vt[i].cnt, vt[i].ovf);
    end

    // asynchronous reset while a lap is shown
    drv(16'd5, 1, 0, 0);
    drv(16'd6, 0, 1, 0);
    chk_all("pre_arst", 16'd5, 3'd1, 3'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 16'h0, 3'd0, 3'd0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    drv(16'd100, 1, 0, 0);
    drv(16'd200, 1, 0, 0);
    drv(16'd300, 0, 1, 0);
    chk_all("to_enter", 16'd100, 3'd1, 3'd2, 1'b0);
`ifdef LAP_DISP_TIMEOUT_EN
    for (int k = 1; k <= 2; k++) begin
      drv(16'd300, 0, 0, 0);
      chk($sformatf("to_hold1_%0d", k), 32'(bus.display_src), 32'd1);
    end
    drv(16'd300, 0, 1, 0);
    chk_all("to_restart", 16'd200, 3'd2, 3'd2, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      drv(16'd300, 0, 0, 0);
      chk($sformatf("to_hold2_%0d", k), 32'(bus.display_src), 32'd2);
    end
    drv(16'd301, 0, 0, 0);
    chk_all("to_expire", 16'd301, 3'd0, 3'd2, 1'b0);
`else
    for (int k = 1; k <= 10; k++) begin
      drv(16'd300, 0, 0, 0);
      chk($sformatf("persist_%0d", k), 32'(bus.display_src), 32'd1);
    end
    chk_all("persist_end", 16'd100, 3'd1, 3'd2, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
